wb_stage_ctrl: RTL

Registered writeback stage for the RISC-V core. It selects among the ALU result, PC+increment and NSRC memory-mapped read sources (DMEM, BIOS, UART, …), and performs RISC-V load extraction (byte/half/word, signed/unsigned) on memory data. It waits, with a timeout, on sources whose read data arrives after a variable latency. It sits between the memory stage and the register file and drives writeback valid, rd and data.

---
 rtl/wb_stage_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : wb_stage_ctrl
// Purpose : Registered writeback stage with load extraction and a bounded
//           wait on variable-latency read sources.
// Revision: 1.0 - initial release
// ============================================================================
module wb_stage_ctrl #(
  parameter  int XLEN    = 32,
  parameter  int NSRC    = 4,
  parameter  int PC_INC  = 4,
  parameter  int TIMEOUT = 16,
  localparam int SW      = (NSRC > 1) ? $clog2(NSRC) : 1,
  localparam int AW      = $clog2(XLEN / 8)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [XLEN-1:0]      in_alu,
  input  logic [1:0]           in_wb_sel,
  input  logic [SW-1:0]        in_mem_sel,
  input  logic [2:0]           in_funct3,
  input  logic [AW-1:0]        in_addr_lo,
  input  logic [4:0]           in_rd,
  input  logic                 in_rf_we,
  input  logic [NSRC*XLEN-1:0] src_rdata,
  input  logic [NSRC-1:0]      src_rvalid,
  output logic                 wb_valid,
  output logic                 wb_we,
  output logic [4:0]           wb_rd,
  output logic [XLEN-1:0]      wb_data,
  output logic                 wb_err
);

  localparam int            CW        = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] c_mask_h  = ~AW'(1);
  localparam logic [AW-1:0] c_mask_w  = ~AW'(3);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [SW-1:0]   r_sel;
  logic [2:0]      r_f3;
  logic [AW-1:0]   r_addr;
  logic [4:0]      r_rd;
  logic            r_rf_we;

  logic            w_accept, w_capture, w_done, w_timeout;
  logic            w_in_wait;
  logic [1:0]      w_wb_sel;
  logic [SW-1:0]   w_sel;
  logic [2:0]      w_f3;
  logic [AW-1:0]   w_addr;
  logic [4:0]      w_rd;
  logic            w_rf_we;
  logic [XLEN-1:0] w_word, w_ext;
  logic            w_rv, w_sel_ok;
  logic [XLEN-1:0] w_lane_b, w_lane_h, w_lane_w;
  logic [XLEN-1:0] w_res_data, w_fin_data;
  logic            w_res_err, w_fin_err, w_fin_we;

  assign in_ready  = (r_state == S_IDLE);
  assign w_in_wait = (r_state == S_WAIT);
  assign w_accept  = in_valid & in_ready & ~flush;

  // While waiting, the captured load replaces the live input fields.
  assign w_wb_sel = w_in_wait ? 2'd1    : in_wb_sel;
  assign w_sel    = w_in_wait ? r_sel   : in_mem_sel;
  assign w_f3     = w_in_wait ? r_f3    : in_funct3;
  assign w_addr   = w_in_wait ? r_addr  : in_addr_lo;
  assign w_rd     = w_in_wait ? r_rd    : in_rd;
  assign w_rf_we  = w_in_wait ? r_rf_we : in_rf_we;

  always_comb begin
    w_word   = '0;
    w_rv     = 1'b0;
    w_sel_ok = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (w_sel == SW'(i)) begin
        w_word   = src_rdata[i*XLEN +: XLEN];
        w_rv     = src_rvalid[i];
        w_sel_ok = 1'b1;
      end
    end
  end

  assign w_lane_b = w_word >> {w_addr, 3'b000};
  assign w_lane_h = w_word >> {w_addr & c_mask_h, 3'b000};
  assign w_lane_w = w_word >> {w_addr & c_mask_w, 3'b000};

  always_comb begin
    w_ext = w_word;
    case (w_f3)
      3'b000:  w_ext = XLEN'($signed(w_lane_b[7:0]));
      3'b100:  w_ext = XLEN'(w_lane_b[7:0]);
      3'b001:  w_ext = XLEN'($signed(w_lane_h[15:0]));
      3'b101:  w_ext = XLEN'(w_lane_h[15:0]);
      3'b010:  w_ext = XLEN'($signed(w_lane_w[31:0]));
      3'b110:  w_ext = XLEN'(w_lane_w[31:0]);
      default: w_ext = w_word;
    endcase
  end

  always_comb begin
    w_res_data = '0;
    w_res_err  = 1'b0;
    case (w_wb_sel)
      2'd0: w_res_data = in_alu;
      2'd1: begin
        if (w_sel_ok) w_res_data = w_ext;
        else          w_res_err  = 1'b1;
      end
      2'd2:    w_res_data = in_pc + XLEN'(PC_INC);
      default: w_res_data = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if ((in_wb_sel == 2'd1) && w_sel_ok && !w_rv) begin
            w_state_nxt = S_WAIT;
            w_capture   = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_done = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else if (w_rv) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_done      = 1'b1;
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_fin_err  = w_res_err | w_timeout;
  assign w_fin_data = w_timeout ? '0 : w_res_data;
  assign w_fin_we   = w_rf_we & (w_rd != 5'd0) & ~w_fin_err & (w_wb_sel != 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_sel    <= '0;
      r_f3     <= '0;
      r_addr   <= '0;
      r_rd     <= '0;
      r_rf_we  <= 1'b0;
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_err   <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      wb_valid <= w_done;
      wb_we    <= w_done & w_fin_we;
      wb_err   <= w_done & w_fin_err;
      if (w_capture) begin
        r_sel   <= in_mem_sel;
        r_f3    <= in_funct3;
        r_addr  <= in_addr_lo;
        r_rd    <= in_rd;
        r_rf_we <= in_rf_we;
      end
      if (w_done) begin
        wb_rd   <= w_rd;
        wb_data <= w_fin_data;
      end
    end
  end

endmodule
`default_nettype wire
